// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared types and default constants for serial_add_ctrl.
//   state_t      - controller FSM state encoding
//   DEF_WIDTH    - default operand/result width
//   DEF_TIMEOUT  - default per-bit fa_done wait limit (watchdog build only)
package serial_add_pkg;

  localparam int unsigned DEF_WIDTH   = 8;
  localparam int unsigned DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_FIN
  } state_t;

endpackage

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller. Walks the operands LSB first,
// handing one bit pair plus the running carry to an external full-adder
// responder per step and collecting its sum/carry on each fa_done rising edge.
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   start               - request pulse, op_a/op_b/cin_init sampled with it
//   op_a, op_b          - WIDTH-bit operands
//   cin_init            - initial carry-in
//   busy                - operation in progress (ISSUE/WAIT/FIN)
//   res_valid           - one-cycle pulse, result/carry_out valid
//   result, carry_out   - sum and final carry, held until the next res_valid
//   fa_a, fa_b, fa_cin  - bit operands to the responder
//   fa_sample           - one-cycle request strobe to the responder
//   fa_sum, fa_cout     - responder outputs, valid on the rising edge of fa_done
//   fa_done             - responder completion
//   err                 - watchdog timeout pulse (only with SERIAL_ADD_TIMEOUT_EN)
//
// Build option: define SERIAL_ADD_TIMEOUT_EN to add the per-bit done-timeout
// watchdog and the err port; without it WAIT waits indefinitely.
module serial_add_ctrl #(
  parameter int unsigned WIDTH   = serial_add_pkg::DEF_WIDTH,
  parameter int unsigned TIMEOUT = serial_add_pkg::DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin_init,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  output logic             fa_sample,
  input  logic             fa_sum,
  input  logic             fa_cout,
  input  logic             fa_done
`ifdef SERIAL_ADD_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  import serial_add_pkg::*;

  localparam int unsigned IDX_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32 || TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_params
    $error("serial_add_ctrl: WIDTH must be 2..32 and TIMEOUT 2..255");
  end

  state_t           state;
  state_t           state_n;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic             carry;
  logic             done_q;
  logic             done_rise;
  logic             last_bit;

  assign done_rise = fa_done & ~done_q;
  assign last_bit  = (idx == IDX_W'(WIDTH - 1));
  assign idx_nxt   = idx + IDX_W'(1);

`ifdef SERIAL_ADD_TIMEOUT_EN
  logic [7:0] wd_cnt;
  logic       timed_out;

  // Counter reads k in the k-th WAIT cycle (from 0), so hitting TIMEOUT-1
  // without an edge means the next count would reach TIMEOUT.
  assign timed_out = (state == S_WAIT) && !done_rise && (wd_cnt == 8'(TIMEOUT - 1));
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    busy      = (state != S_IDLE);
    res_valid = 1'b0;
    fa_sample = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_n = S_ISSUE;
      end
      S_ISSUE: begin
        fa_sample = 1'b1;
        state_n   = S_WAIT;
      end
      S_WAIT: begin
        if (done_rise) begin
          state_n = last_bit ? S_FIN : S_ISSUE;
        end
`ifdef SERIAL_ADD_TIMEOUT_EN
        else if (timed_out) begin
          state_n = S_IDLE;
        end
`endif
      end
      S_FIN: begin
        res_valid = 1'b1;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Partial sums build up in acc; result/carry_out only update on the final
  // bit, so they stay stable between res_valid pulses and across aborts.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      acc       <= '0;
      idx       <= '0;
      carry     <= 1'b0;
      done_q    <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      fa_a      <= 1'b0;
      fa_b      <= 1'b0;
      fa_cin    <= 1'b0;
`ifdef SERIAL_ADD_TIMEOUT_EN
      wd_cnt    <= '0;
      err       <= 1'b0;
`endif
    end else begin
      done_q <= fa_done;
`ifdef SERIAL_ADD_TIMEOUT_EN
      err    <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q    <= op_a;
            b_q    <= op_b;
            carry  <= cin_init;
            acc    <= '0;
            idx    <= '0;
            fa_a   <= op_a[0];
            fa_b   <= op_b[0];
            fa_cin <= cin_init;
          end
        end
        S_ISSUE: begin
`ifdef SERIAL_ADD_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT: begin
          if (done_rise) begin
            acc[idx] <= fa_sum;
            carry    <= fa_cout;
            if (last_bit) begin
              result    <= {fa_sum, acc[WIDTH-2:0]};
              carry_out <= fa_cout;
            end else begin
              idx    <= idx_nxt;
              fa_a   <= a_q[idx_nxt];
              fa_b   <= b_q[idx_nxt];
              fa_cin <= fa_cout;
            end
          end
`ifdef SERIAL_ADD_TIMEOUT_EN
          else if (timed_out) begin
            err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + 8'd1;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits (legal range 2..32).
REQ-002 Parameter: TIMEOUT, default 16, maximum cycles to wait for fa_done per bit (legal range 2..255).
REQ-003 Port: clk  in  1  single clock; all logic on posedge clk.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: start  in  1  request pulse; operands valid in the same cycle.
REQ-006 Port: op_a, op_b  in  WIDTH  operands.
REQ-007 Port: cin_init  in  1  initial carry-in.
REQ-008 Port: busy  out  1  high from the cycle after an accepted start until return to IDLE.
REQ-009 Port: res_valid  out  1  one-cycle pulse; result and carry_out valid.
REQ-010 Port: result  out  WIDTH  sum; carry_out  out  1  final carry.
REQ-011 Port: fa_a, fa_b, fa_cin  out  1 each  bit operands to the external full-adder responder.
REQ-012 Port: fa_sample  out  1  one-cycle request strobe to the responder.
REQ-013 Port: fa_sum, fa_cout, fa_done  in  1 each  responder outputs; fa_sum and fa_cout are valid on the rising edge of fa_done.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT, FIN.
REQ-015 IDLE: start=1 latches op_a, op_b and cin_init, clears the bit index to 0, and goes to ISSUE.
REQ-016 ISSUE, one cycle: fa_sample=1; fa_a=op_a[idx], fa_b=op_b[idx], fa_cin=carry; next state WAIT.
REQ-017 fa_a, fa_b and fa_cin hold their values through ISSUE and WAIT; fa_sample is 0 in every state except ISSUE.
REQ-018 WAIT: a rising edge of fa_done (fa_done=1 with registered previous fa_done=0) loads result[idx]<=fa_sum and carry<=fa_cout.
REQ-019 WAIT, on that edge: if idx==WIDTH-1, go to FIN; otherwise idx<=idx+1 and go to ISSUE. Bits are processed LSB first.
REQ-020 A level-high fa_done that is already high on entry to WAIT is not a rising edge and is not captured.
REQ-021 FIN, one cycle: res_valid=1, carry_out=carry; next state IDLE.
REQ-022 result and carry_out hold their values until the next res_valid.
REQ-023 start while busy is ignored; start in the FIN cycle is ignored.
REQ-024 Latency: the first fa_sample comes 1 cycle after start. With a responder whose done edge arrives D cycles after sample, res_valid follows start by WIDTH*(D+1)+1 cycles.
REQ-025 fa_done edges seen outside WAIT are ignored.

Reset
REQ-026 rst=1 at any posedge returns the FSM to IDLE, including mid-operation, and discards the partial result.
REQ-027 Reset values: busy, res_valid, fa_sample, fa_a, fa_b, fa_cin, carry_out, err are 0; result is 0; idx is 0; the registered previous fa_done is 0.

Configuration
REQ-028 Macro SERIAL_ADD_TIMEOUT_EN selects the done-timeout watchdog.
REQ-029 With SERIAL_ADD_TIMEOUT_EN defined: port err (out, 1) exists. A counter clears in ISSUE and increments each WAIT cycle.
REQ-030 With SERIAL_ADD_TIMEOUT_EN defined: if the counter reaches TIMEOUT without a done edge, err pulses 1 cycle, the FSM goes to IDLE, no res_valid is issued, and result is unchanged.
REQ-031 Without SERIAL_ADD_TIMEOUT_EN: no err port and no counter; WAIT waits indefinitely.

Structure
REQ-032 Package serial_add_pkg holds the state enum type and the default constants for WIDTH and TIMEOUT.
REQ-033 The design is a single module; no sub-module.

Verification
REQ-034 Bench responder model: registers a, b and cin on sample and raises done 2 cycles later for 1 cycle.
REQ-035 op_a=8'h0F, op_b=8'h01, cin_init=0 -> result=8'h10, carry_out=0; res_valid arrives 25 cycles after start; exactly 8 fa_sample pulses.
REQ-036 op_a=8'hFF, op_b=8'h01, cin_init=0 -> result=8'h00, carry_out=1; op_a=8'hA5, op_b=8'h5A, cin_init=1 -> result=8'h00, carry_out=1.
REQ-037 Second start pulse 3 cycles after the first, with different operands -> ignored; exactly one res_valid carrying the first operands' sum.
REQ-038 rst asserted for 1 cycle during bit 4 -> busy=0 and fa_sample=0 next cycle, no res_valid; a subsequent 8'h03+8'h04 -> 8'h07.
REQ-039 With SERIAL_ADD_TIMEOUT_EN defined and the responder muted on bit 2 -> err pulses exactly once, TIMEOUT cycles after entering WAIT, then busy=0; no res_valid.
